// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// The optional response timeout is enabled with MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

    localparam int GNT_W = 1;

    localparam logic [31:0] ARB_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Clearable saturating 8-bit cycle counter with an expiry flag at TIMEOUT-1.
// Only instantiated by mem_arbiter when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two valid/ready masters access to one memory slave.
// Define MEM_ARB_TIMEOUT_EN to add a slave response timeout with error reporting.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 14,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_valid,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wstrb,
    output logic [31:0]   m0_rdata,
    output logic          m0_ready,
    output logic          m0_err,
    input  logic          m1_valid,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wstrb,
    output logic [31:0]   m1_rdata,
    output logic          m1_ready,
    output logic          m1_err,
    output logic          s_valid,
    output logic [AW-1:0] s_addr,
    output logic [31:0]   s_wdata,
    output logic [3:0]    s_wstrb,
    input  logic [31:0]   s_rdata,
    input  logic          s_ready
);

    state_t             r_state;
    logic [GNT_W-1:0]   r_grant;
    logic [GNT_W-1:0]   r_last_grant;
    logic               r_s_valid;
    logic [AW-1:0]      r_s_addr;
    logic [31:0]        r_s_wdata;
    logic [3:0]         r_s_wstrb;
    logic [31:0]        r_m0_rdata;
    logic [31:0]        r_m1_rdata;
    logic               r_m0_ready;
    logic               r_m1_ready;

    logic               w_req_any;
    logic [GNT_W-1:0]   w_gnt_idx;
    logic [AW-1:0]      w_addr;
    logic [31:0]        w_wdata;
    logic [3:0]         w_wstrb;

    // On a tie the master that did not finish last wins.
    assign w_req_any = m0_valid | m1_valid;
    assign w_gnt_idx = (m0_valid && m1_valid) ? ~r_last_grant : GNT_W'(m1_valid);
    assign w_addr    = w_gnt_idx[0] ? m1_addr  : m0_addr;
    assign w_wdata   = w_gnt_idx[0] ? m1_wdata : m0_wdata;
    assign w_wstrb   = w_gnt_idx[0] ? m1_wstrb : m0_wstrb;

`ifdef MEM_ARB_TIMEOUT_EN
    logic r_m0_err;
    logic r_m1_err;
    logic w_expired;

    mem_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   ((r_state == ST_IDLE) && w_req_any),
        .i_enable  (r_state == ST_ISSUE),
        .o_expired (w_expired)
    );

    assign m0_err = r_m0_err;
    assign m1_err = r_m1_err;
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= 1'b1;
            r_s_valid    <= 1'b0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
            r_s_wstrb    <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_m0_ready   <= 1'b0;
            r_m1_ready   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_m0_err     <= 1'b0;
            r_m1_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_grant   <= w_gnt_idx;
                        r_s_addr  <= w_addr;
                        r_s_wdata <= w_wdata;
                        r_s_wstrb <= w_wstrb;
                        r_s_valid <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A same-cycle slave ready takes priority over expiry.
                    if (s_ready) begin
                        r_s_valid    <= 1'b0;
                        r_last_grant <= r_grant;
                        r_state      <= ST_DONE;
                        if (r_grant == 1'b0) begin
                            r_m0_rdata <= s_rdata;
                            r_m0_ready <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                            r_m0_err   <= 1'b0;
`endif
                        end else begin
                            r_m1_rdata <= s_rdata;
                            r_m1_ready <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                            r_m1_err   <= 1'b0;
`endif
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (w_expired) begin
                        r_s_valid    <= 1'b0;
                        r_last_grant <= r_grant;
                        r_state      <= ST_DONE;
                        if (r_grant == 1'b0) begin
                            r_m0_rdata <= ARB_ERR_DATA;
                            r_m0_ready <= 1'b1;
                            r_m0_err   <= 1'b1;
                        end else begin
                            r_m1_rdata <= ARB_ERR_DATA;
                            r_m1_ready <= 1'b1;
                            r_m1_err   <= 1'b1;
                        end
                    end
`endif
                end
                ST_DONE: begin
                    r_m0_ready <= 1'b0;
                    r_m1_ready <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    r_m0_err   <= 1'b0;
                    r_m1_err   <= 1'b0;
`endif
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_valid  = r_s_valid;
    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign s_wstrb  = r_s_wstrb;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    assign m0_ready = r_m0_ready;
    assign m1_ready = r_m1_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 1-cycle RAM slave model.
// Exercises the timeout path when MEM_ARB_TIMEOUT_EN is defined (TIMEOUT=4).
module tb_mem_arbiter;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_valid;
    logic [AW-1:0] m0_addr;
    logic [31:0]   m0_wdata;
    logic [3:0]    m0_wstrb;
    logic [31:0]   m0_rdata;
    logic          m0_ready;
    logic          m0_err;
    logic          m1_valid;
    logic [AW-1:0] m1_addr;
    logic [31:0]   m1_wdata;
    logic [3:0]    m1_wstrb;
    logic [31:0]   m1_rdata;
    logic          m1_ready;
    logic          m1_err;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic [31:0]   s_rdata = 32'h0;
    logic          s_ready = 1'b0;

    logic          slave_en;
    logic [31:0]   mem [0:63];

    int n_vec = 0;
    int n_err = 0;
    int edges;

    mem_arbiter #(
        .AW      (AW),
        .TIMEOUT (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_valid (m0_valid),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_rdata (m0_rdata),
        .m0_ready (m0_ready),
        .m0_err   (m0_err),
        .m1_valid (m1_valid),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_rdata (m1_rdata),
        .m1_ready (m1_ready),
        .m1_err   (m1_err),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_rdata  (s_rdata),
        .s_ready  (s_ready)
    );

    always #5 clk = ~clk;

    // 1-cycle RAM: answers every cycle it samples s_valid, so it naturally
    // produces a second (stale) ready right after each completion.
    always @(posedge clk) begin
        if (s_valid && slave_en) begin
            s_ready <= 1'b1;
            s_rdata <= mem[s_addr[7:2]];
            for (int b = 0; b < 4; b++) begin
                if (s_wstrb[b]) mem[s_addr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
            end
        end else begin
            s_ready <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wait_rdy(input bit which, output int cnt);
        cnt = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((which ? m1_ready : m0_ready) === 1'b1) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic run_txn(input bit which, input logic [AW-1:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input bit keep, output int cnt);
        if (which) begin
            m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_valid = 1'b1;
        end else begin
            m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_valid = 1'b1;
        end
        wait_rdy(which, cnt);
        if (!keep) begin
            if (which) m1_valid = 1'b0;
            else       m0_valid = 1'b0;
        end
    endtask

    initial begin
        int got;
        int n_rdy;
        bit prev0;
        bit prev1;
        reset    = 1'b1;
        slave_en = 1'b1;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h12345678;
        repeat (2) @(negedge clk);

        chk("rst_s_valid", 32'(s_valid), 32'h0);
        chk("rst_s_addr", 32'(s_addr), 32'h0);
        chk("rst_m0_ready", 32'(m0_ready), 32'h0);
        chk("rst_m1_ready", 32'(m1_ready), 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        chk("rst_m0_err", 32'(m0_err), 32'h0);
        reset = 1'b0;

        // Single read, edge by edge
        @(negedge clk);
        m0_addr = 14'h0010; m0_wstrb = 4'b0000; m0_valid = 1'b1;
        @(negedge clk);
        chk("rd_s_valid_e1", 32'(s_valid), 32'h1);
        chk("rd_s_addr_e1", 32'(s_addr), 32'h10);
        @(negedge clk);
        chk("rd_m0_ready_e2", 32'(m0_ready), 32'h0);
        @(negedge clk);
        chk("rd_m0_ready_e3", 32'(m0_ready), 32'h1);
        chk("rd_m0_rdata", m0_rdata, 32'h12345678);
        chk("rd_m0_err", 32'(m0_err), 32'h0);
        chk("rd_m1_ready", 32'(m1_ready), 32'h0);
        chk("rd_s_valid_e3", 32'(s_valid), 32'h0);
        m0_valid = 1'b0;
        @(negedge clk);
        chk("rd_ready_pulse", 32'(m0_ready), 32'h0);
        @(negedge clk);

        // Byte write then read-back from master 1
        run_txn(1'b1, 14'h0020, 32'hAABBCCDD, 4'b0010, 1'b0, edges);
        chk("wr_edges", 32'(edges), 32'd3);
        chk("wr_m0_quiet", 32'(m0_ready), 32'h0);
        @(negedge clk);
        run_txn(1'b1, 14'h0020, 32'h0, 4'b0000, 1'b0, edges);
        chk("wr_rb_edges", 32'(edges), 32'd3);
        chk("wr_rb_rdata", m1_rdata, 32'h0000CC00);
        @(negedge clk);

        // Back-to-back reads: the stale ready during DONE must not complete the second
        run_txn(1'b0, 14'h0010, 32'h0, 4'b0000, 1'b1, edges);
        chk("b2b_first_edges", 32'(edges), 32'd3);
        chk("b2b_first_rdata", m0_rdata, 32'h12345678);
        run_txn(1'b0, 14'h0020, 32'h0, 4'b0000, 1'b0, edges);
        chk("b2b_second_edges", 32'(edges), 32'd4);
        chk("b2b_second_rdata", m0_rdata, 32'h0000CC00);
        @(negedge clk);
        chk("b2b_single_pulse", 32'(m0_ready), 32'h0);
        @(negedge clk);

        // Contention from reset: expect m0, m1, m0, m1
        reset = 1'b1;
        m0_addr = 14'h0010; m0_wstrb = 4'b0000; m0_valid = 1'b1;
        m1_addr = 14'h0020; m1_wstrb = 4'b0000; m1_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        got = 0; prev0 = 1'b0; prev1 = 1'b0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                chk("cont_both_ready", 32'(m0_ready & m1_ready), 32'h0);
                chk("cont_order", 32'(m1_ready), 32'(got % 2));
                chk("cont_s_valid_low", 32'(s_valid), 32'h0);
                chk("cont_pulse", 32'(prev0 | prev1), 32'h0);
                if (m0_ready) chk("cont_m0_rdata", m0_rdata, 32'h12345678);
                else          chk("cont_m1_rdata", m1_rdata, 32'h0000CC00);
                got++;
            end
            prev0 = m0_ready;
            prev1 = m1_ready;
        end
        chk("cont_count", 32'(got), 32'd4);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during ISSUE
        m1_addr = 14'h0020; m1_wstrb = 4'b0000; m1_valid = 1'b1;
        @(posedge clk);
        #2;
        chk("rmid_s_valid_before", 32'(s_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("rmid_s_valid", 32'(s_valid), 32'h0);
        chk("rmid_s_addr", 32'(s_addr), 32'h0);
        chk("rmid_m0_ready", 32'(m0_ready), 32'h0);
        chk("rmid_m1_ready", 32'(m1_ready), 32'h0);
        m0_addr = 14'h0010; m0_wstrb = 4'b0000; m0_valid = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rmid_tie_m0", 32'(s_addr), 32'h10);
        wait_rdy(1'b0, edges);
        chk("rmid_m0_edges", 32'(edges), 32'd2);
        chk("rmid_m0_rdata", m0_rdata, 32'h12345678);
        m0_valid = 1'b0;
        wait_rdy(1'b1, edges);
        chk("rmid_m1_edges", 32'(edges), 32'd4);
        chk("rmid_m1_rdata", m1_rdata, 32'h0000CC00);
        m1_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Silent slave
        slave_en = 1'b0;
        m0_addr = 14'h0010; m0_wstrb = 4'b0000; m0_valid = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_rdy(1'b0, edges);
        chk("to_edges", 32'(edges), 32'd5);
        chk("to_err", 32'(m0_err), 32'h1);
        chk("to_rdata", m0_rdata, 32'hDEADBEEF);
        chk("to_s_valid", 32'(s_valid), 32'h0);
        m0_valid = 1'b0;
        @(negedge clk);
        chk("to_err_clear", 32'(m0_err), 32'h0);
        chk("to_ready_clear", 32'(m0_ready), 32'h0);
`else
        n_rdy = 0;
        repeat (1000) begin
            @(negedge clk);
            if (m0_ready) n_rdy++;
        end
        chk("hang_no_ready", 32'(n_rdy), 32'd0);
        chk("hang_s_valid", 32'(s_valid), 32'h1);
        chk("hang_err", 32'(m0_err), 32'h0);
        slave_en = 1'b1;
        wait_rdy(1'b0, edges);
        chk("hang_resume", 32'(m0_ready), 32'h1);
        chk("hang_resume_rdata", m0_rdata, 32'h12345678);
        m0_valid = 1'b0;
`endif
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
